// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data/memory bundle for the memory port arbiter
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   // fetch requester
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   // data requester
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [1:0]        d_size;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   // backing memory
   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic [1:0]        m_size;
   logic              m_ack;
   logic [DATA_W-1:0] m_rdata;

   // requesters and memory model side
   modport master (
      output if_req, if_addr, if_flush,
      input  if_gnt, if_rvalid, if_rdata,
      output d_req, d_we, d_addr, d_wdata, d_size,
      input  d_gnt, d_rvalid, d_rdata,
      input  m_req, m_we, m_addr, m_wdata, m_size,
      output m_ack, m_rdata
   );

   // arbiter side
   modport slave (
      input  if_req, if_addr, if_flush,
      output if_gnt, if_rvalid, if_rdata,
      input  d_req, d_we, d_addr, d_wdata, d_size,
      output d_gnt, d_rvalid, d_rdata,
      output m_req, m_we, m_addr, m_wdata, m_size,
      input  m_ack, m_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port shared by fetch and data with starvation guard
module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   mem_port_arbiter_if.slave bus
);
   localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY_IF, ST_BUSY_D} state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_starve;
   logic              r_drop;
   logic              r_m_req;
   logic              r_m_we;
   logic [ADDR_W-1:0] r_m_addr;
   logic [DATA_W-1:0] r_m_wdata;
   logic [1:0]        r_m_size;
   logic              r_if_rvalid;
   logic [DATA_W-1:0] r_if_rdata;
   logic              r_d_rvalid;
   logic [DATA_W-1:0] r_d_rdata;

   logic              w_idle;
   logic              w_d_win;
   logic              w_if_win;
   logic              w_if_drop;

   // Grants are decided only while the port is free; data wins unless fetch has waited too long.
   assign w_idle    = (r_state == ST_IDLE) && !i_rst;
   assign w_d_win   = w_idle && bus.d_req && (!bus.if_req || (r_starve < CNT_MAX));
   assign w_if_win  = w_idle && bus.if_req && !w_d_win;
   // A flush in the ack cycle itself must also squash the response.
   assign w_if_drop = r_drop || bus.if_flush;

   assign bus.if_gnt    = w_if_win;
   assign bus.d_gnt     = w_d_win;
   assign bus.if_rvalid = r_if_rvalid;
   assign bus.if_rdata  = r_if_rdata;
   assign bus.d_rvalid  = r_d_rvalid;
   assign bus.d_rdata   = r_d_rdata;
   assign bus.m_req     = r_m_req;
   assign bus.m_we      = r_m_we;
   assign bus.m_addr    = r_m_addr;
   assign bus.m_wdata   = r_m_wdata;
   assign bus.m_size    = r_m_size;

   // Arbitration FSM: latch the winner into the memory request, hold it until ack, route the response.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_starve    <= '0;
         r_drop      <= 1'b0;
         r_m_req     <= 1'b0;
         r_m_we      <= 1'b0;
         r_m_addr    <= '0;
         r_m_wdata   <= '0;
         r_m_size    <= 2'd0;
         r_if_rvalid <= 1'b0;
         r_if_rdata  <= '0;
         r_d_rvalid  <= 1'b0;
         r_d_rdata   <= '0;
      end else begin
         r_if_rvalid <= 1'b0;
         r_d_rvalid  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_d_win) begin
                  r_state   <= ST_BUSY_D;
                  r_m_req   <= 1'b1;
                  r_m_we    <= bus.d_we;
                  r_m_addr  <= bus.d_addr;
                  r_m_wdata <= bus.d_wdata;
                  r_m_size  <= bus.d_size;
                  if (!bus.if_req) begin
                     r_starve <= '0;
                  end else if (r_starve != CNT_MAX) begin
                     r_starve <= r_starve + 1'b1;
                  end
               end else if (w_if_win) begin
                  r_state   <= ST_BUSY_IF;
                  r_m_req   <= 1'b1;
                  r_m_we    <= 1'b0;
                  r_m_addr  <= bus.if_addr;
                  r_m_wdata <= '0;
                  r_m_size  <= 2'd2;
                  r_starve  <= '0;
                  r_drop    <= 1'b0;
               end
            end
            ST_BUSY_IF: begin
               if (bus.if_flush) begin
                  r_drop <= 1'b1;
               end
               if (bus.m_ack) begin
                  r_state <= ST_IDLE;
                  r_m_req <= 1'b0;
                  r_drop  <= 1'b0;
                  if (!w_if_drop) begin
                     r_if_rvalid <= 1'b1;
                     r_if_rdata  <= bus.m_rdata;
                  end
               end
            end
            ST_BUSY_D: begin
               if (bus.m_ack) begin
                  r_state    <= ST_IDLE;
                  r_m_req    <= 1'b0;
                  r_d_rvalid <= 1'b1;
                  r_d_rdata  <= bus.m_rdata;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_m_req <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 4;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;

   always #5 i_clk = ~i_clk;

   mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: who owns the memory, how many data grants fetch has sat through, squash pending
   int          owner     = 0;   // 0 free, 1 fetch, 2 data
   int          d_streak  = 0;
   bit          squash    = 0;
   logic        e_m_req   = 0;
   logic        e_m_we    = 0;
   logic [31:0] e_m_addr  = 0;
   logic [31:0] e_m_wdata = 0;
   logic [1:0]  e_m_size  = 0;
   logic        e_if_rv   = 0;
   logic [31:0] e_if_rd   = 0;
   logic        e_d_rv    = 0;
   logic [31:0] e_d_rd    = 0;

   bit x_if, x_d;      // model grants this cycle
   bit o_if, o_d;      // observed grants this cycle
   bit done_if, done_d;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic quiet();
      bus.if_req   = 0; bus.if_addr = 0; bus.if_flush = 0;
      bus.d_req    = 0; bus.d_we    = 0; bus.d_addr   = 0;
      bus.d_wdata  = 0; bus.d_size  = 0;
      bus.m_ack    = 0; bus.m_rdata = 0;
   endtask

   // One clock cycle: inputs are already applied; check grants, advance model, check registered outputs.
   task automatic step();
      #1;
      x_d  = !i_rst && owner == 0 && bus.d_req && (!bus.if_req || d_streak < STARVE_MAX);
      x_if = !i_rst && owner == 0 && bus.if_req && !x_d;
      o_if = bus.if_gnt;
      o_d  = bus.d_gnt;
      chk("if_gnt", o_if, x_if);
      chk("d_gnt", o_d, x_d);
      done_if = 0;
      done_d  = 0;
      e_if_rv = 0;
      e_d_rv  = 0;
      if (i_rst) begin
         owner = 0; d_streak = 0; squash = 0;
         e_m_req = 0; e_m_we = 0; e_m_addr = 0; e_m_wdata = 0; e_m_size = 0;
         e_if_rd = 0; e_d_rd = 0;
      end else if (owner == 0) begin
         if (x_d) begin
            owner = 2;
            e_m_req = 1; e_m_we = bus.d_we; e_m_addr = bus.d_addr;
            e_m_wdata = bus.d_wdata; e_m_size = bus.d_size;
            if (!bus.if_req) d_streak = 0;
            else if (d_streak < STARVE_MAX) d_streak++;
         end else if (x_if) begin
            owner = 1;
            e_m_req = 1; e_m_we = 0; e_m_addr = bus.if_addr;
            e_m_wdata = 0; e_m_size = 2;
            d_streak = 0;
            squash = 0;
         end
      end else begin
         if (owner == 1 && bus.if_flush) squash = 1;
         if (bus.m_ack) begin
            if (owner == 2) begin
               e_d_rv = 1; e_d_rd = bus.m_rdata; done_d = 1;
            end else begin
               if (!squash) begin
                  e_if_rv = 1; e_if_rd = bus.m_rdata;
               end
               done_if = 1;
               squash = 0;
            end
            owner = 0;
            e_m_req = 0;
         end
      end
      @(posedge i_clk);
      #1;
      chk("if_rvalid", bus.if_rvalid, e_if_rv);
      chk("if_rdata", bus.if_rdata, e_if_rd);
      chk("d_rvalid", bus.d_rvalid, e_d_rv);
      chk("d_rdata", bus.d_rdata, e_d_rd);
      chk("m_req", bus.m_req, e_m_req);
      chk("m_we", bus.m_we, e_m_we);
      chk("m_addr", bus.m_addr, e_m_addr);
      chk("m_wdata", bus.m_wdata, e_m_wdata);
      chk("m_size", bus.m_size, e_m_size);
   endtask

   initial begin
      int if_st;
      int d_st;
      quiet();

      // reset state
      i_rst = 1;
      step();
      step();
      i_rst = 0;
      chk("rst_m_req", bus.m_req, 0);
      chk("rst_m_addr", bus.m_addr, 0);
      chk("rst_if_rvalid", bus.if_rvalid, 0);
      chk("rst_d_rdata", bus.d_rdata, 0);

      // single load
      bus.d_req = 1; bus.d_addr = 32'h100; bus.d_we = 0; bus.d_size = 2;
      step();
      chk("load_gnt", o_d, 1);
      bus.d_req = 0;
      chk("load_m_req_t1", bus.m_req, 1);
      chk("load_m_addr_t1", bus.m_addr, 32'h100);
      step();
      step();
      bus.m_ack = 1; bus.m_rdata = 32'hDEADBEEF;
      step();
      bus.m_ack = 0;
      chk("load_rvalid_t4", bus.d_rvalid, 1);
      chk("load_rdata_t4", bus.d_rdata, 32'hDEADBEEF);
      chk("load_if_rvalid_t4", bus.if_rvalid, 0);

      // tie: data first, fetch right after the data ack
      bus.if_req = 1; bus.if_addr = 32'h400;
      bus.d_req = 1; bus.d_addr = 32'h800; bus.d_we = 1; bus.d_wdata = 32'h1234_5678; bus.d_size = 1;
      step();
      chk("tie_d_gnt", o_d, 1);
      chk("tie_if_gnt", o_if, 0);
      bus.d_req = 0;
      step();
      chk("tie_if_wait", o_if, 0);
      bus.m_ack = 1; bus.m_rdata = 32'h0BAD_F00D;
      step();
      bus.m_ack = 0;
      chk("tie_store_rdata", bus.d_rdata, 32'h0BAD_F00D);
      step();
      chk("tie_if_gnt_after", o_if, 1);
      bus.if_req = 0;
      bus.m_ack = 1; bus.m_rdata = 32'h0000_0013;
      step();
      bus.m_ack = 0;
      chk("tie_if_rdata", bus.if_rdata, 32'h13);

      // starvation: four data grants, then fetch
      bus.if_req = 1; bus.if_addr = 32'h1000;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h2000; bus.d_size = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("starve_d_gnt%0d", k), o_d, (k < 4) ? 1 : 0);
         chk($sformatf("starve_if_gnt%0d", k), o_if, (k == 4) ? 1 : 0);
         if (k == 4) begin
            bus.if_req = 0;
            bus.d_req = 0;
         end
         bus.m_ack = 1; bus.m_rdata = 32'hA000 + k;
         step();
         bus.m_ack = 0;
      end
      chk("starve_if_rvalid", bus.if_rvalid, 1);

      // flush in the ack cycle
      bus.if_req = 1; bus.if_addr = 32'h3000;
      step();
      chk("flush_if_gnt", o_if, 1);
      bus.if_req = 0;
      step();
      bus.if_flush = 1; bus.m_ack = 1; bus.m_rdata = 32'hFFFF_0000;
      step();
      bus.if_flush = 0; bus.m_ack = 0;
      chk("flush_no_rvalid", bus.if_rvalid, 0);
      bus.d_req = 1; bus.d_addr = 32'h3004; bus.d_we = 0; bus.d_size = 2;
      step();
      chk("flush_d_gnt_t3", o_d, 1);
      bus.d_req = 0;
      bus.m_ack = 1; bus.m_rdata = 32'h5555_AAAA;
      step();
      bus.m_ack = 0;

      // zero-wait memory, alternating requesters
      for (int i = 0; i < 6; i++) begin
         if (i > 0) chk($sformatf("zw_rvalid%0d", i), (i % 2 == 1) ? bus.d_rvalid : bus.if_rvalid, 1);
         if (i % 2 == 0) begin
            bus.d_req = 1; bus.d_addr = 32'h5000 + i * 4; bus.d_wdata = i; bus.d_we = i[1];
         end else begin
            bus.if_req = 1; bus.if_addr = 32'h6000 + i * 4;
         end
         step();
         chk($sformatf("zw_gnt%0d", i), (i % 2 == 0) ? o_d : o_if, 1);
         bus.d_req = 0; bus.if_req = 0;
         bus.m_ack = 1; bus.m_rdata = 32'hC000 + i;
         step();
         bus.m_ack = 0;
      end
      step();

      // reset in the middle of a data access
      bus.d_req = 1; bus.d_addr = 32'h7000; bus.d_we = 1; bus.d_wdata = 32'h77; bus.d_size = 2;
      step();
      bus.d_req = 0;
      step();
      chk("rstmid_busy", bus.m_req, 1);
      i_rst = 1;
      step();
      i_rst = 0;
      chk("rstmid_m_req", bus.m_req, 0);
      chk("rstmid_m_addr", bus.m_addr, 0);
      chk("rstmid_m_wdata", bus.m_wdata, 0);
      chk("rstmid_d_rdata", bus.d_rdata, 0);
      bus.m_ack = 1; bus.m_rdata = 32'h9999;
      step();
      bus.m_ack = 0;
      chk("rstmid_late_ack", bus.d_rvalid, 0);
      quiet();

      // randomized traffic against the model
      if_st = 0;
      d_st  = 0;
      for (int c = 0; c < 3000; c++) begin
         if (if_st == 0 && $urandom_range(3) == 0) begin
            if_st = 1;
            bus.if_addr = $urandom;
         end
         bus.if_req = (if_st == 1);
         if (d_st == 0 && $urandom_range(2) == 0) begin
            d_st = 1;
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_we    = $urandom_range(1);
            bus.d_size  = 2'($urandom_range(2));
         end
         bus.d_req    = (d_st == 1);
         bus.if_flush = ($urandom_range(7) == 0);
         bus.m_ack    = e_m_req ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
         bus.m_rdata  = $urandom;
         step();
         if (x_if) if_st = 2;
         if (x_d) d_st = 2;
         if (done_if) if_st = 0;
         if (done_d) d_st = 0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
